cache_fill_controller: RTL and testbench
========================================

Name: cache_fill_controller

Overview:
- Read/fill side of the SuperFX 512-byte instruction cache: 32 blocks of 16 bytes.
- Consumes the 32 per-block dirty (valid) bits and produces their set/selector strobe.
- Serves opcode fetches from internal cache RAM on a hit.
- On a miss, fetches the whole 16-byte block from the ROM/RAM bus, then marks it valid.
- PCs outside the cache window are bypassed to the bus as single-byte reads.

Parameters:
- BLOCKS, 32, number of cache blocks; must equal the dirty-bit width.
- BLOCK_BYTES, 16, bytes per block; fixed at 16 (4-bit byte counter).

Ports:
- clk  in  1  main clock; all state is posedge.
- clr  in  1  asynchronous active-high reset.
- req  in  1  fetch request; sampled only in IDLE.
- pc  in  16  fetch address.
- cbr  in  16  cache base register; bits [3:0] are 0.
- flush  in  1  cache flush in progress (same cycle the dirty bits are cleared).
- dirty_bits  in  32  per-block valid bits.
- set  out  1  one-cycle strobe that marks a block valid.
- selector  out  32  one-hot block select; nonzero only while set=1.
- rdy  out  1  one-cycle pulse; data is valid this cycle.
- data  out  8  fetched byte.
- bus_req  out  1  bus read request.
- bus_addr  out  16  bus read address.
- bus_ack  in  1  bus read complete; bus_data is valid this cycle.
- bus_data  in  8  bus read data.

Behaviour:
- Reset (clr=1, asynchronous):
  - State goes to IDLE; byte counter, abort flag, latched pc/offset all 0.
  - set=0, selector=0, rdy=0, data=0, bus_req=0, bus_addr=0.
  - Cache RAM is not reset.
- Offset: off = pc - cbr, modulo 2^16. The fetch is in window iff off < 512. pc < cbr therefore wraps and is out of window. blk = off[8:4], byte = off[3:0].
- States: IDLE, HIT, FILL, MARK, SERVE, BYPASS.
- IDLE:
  - On a posedge with req=1, latch pc and off.
  - In window and dirty_bits[blk]=1 -> HIT.
  - In window and dirty_bits[blk]=0 -> FILL, with counter=0 and abort=0.
  - Out of window -> BYPASS.
  - req=0 -> stay in IDLE.
- HIT: rdy=1 for one cycle, data=RAM[off]. Next state is IDLE.
  - Latency: req sampled at edge N gives rdy high in the cycle after edge N+1.
- FILL:
  - bus_req=1 and bus_addr={cbr[15:9]+carry, ...} = cbr + {blk,4'h0} + counter.
  - bus_addr is registered, updating the cycle after each ack.
  - On a posedge with bus_ack=1: RAM[{blk,counter}] <= bus_data, then counter increments.
  - bus_req stays high between bytes.
  - On the ack with counter=15 -> MARK, and bus_req drops.
  - Bytes are always fetched 0..15 in order, regardless of the requested byte.
- flush during a fill:
  - flush=1 on any cycle in FILL or MARK sets abort.
  - The fill still completes and the requested byte is still served.
- MARK: set=1 for one cycle, unless abort=1. selector = 1<<blk when set=1, else 0. Next state is SERVE.
  - Dirty bits update on the following negedge, so they are visible at the next posedge in IDLE.
- SERVE: rdy=1 and data=RAM[off] for one cycle. Next state is IDLE.
- BYPASS: bus_req=1 with bus_addr=pc until bus_ack.
  - On ack, data<=bus_data and rdy=1 the following cycle, then IDLE.
  - No RAM write and no set.
- Request and flush interaction:
  - req is ignored outside IDLE; the requester must hold req until rdy.
  - A new req may be accepted at the posedge following a rdy cycle.
  - flush in IDLE or HIT has no effect on this block.
  - A req sampled in IDLE uses the dirty_bits value present at that posedge.
- Reset during an operation: everything returns to IDLE immediately.
  - No set is emitted, and a partially filled block stays invalid.
- Outputs rdy, set, selector, bus_req, bus_addr and data are registered.
- rdy and set are never high in the same cycle.

Test Plan:
- Cold miss:
  - Stimulus: clr, all dirty_bits=0, cbr=0x8000, pc=0x8123, bus acks every cycle with bus_data = addr[7:0].
  - Required: 16 reads at 0x8120..0x812F; one set pulse with selector=0x00040000; then rdy with data=0x23.
- Hit after fill:
  - Stimulus: repeat pc=0x812A with dirty bit 18 now set.
  - Required: no bus_req; rdy one cycle after acceptance; data=0x2A.
- Window boundary:
  - Stimulus: cbr=0x8000. pc=0x81FF, then 0x8200, then 0x7FFF.
  - Required: 0x81FF fills block 31 (selector=0x80000000); 0x8200 and 0x7FFF bypass, each with a single bus read at pc and no set.
- Flush mid-fill:
  - Stimulus: flush=1 after the 5th ack.
  - Required: all 16 reads still complete; set stays 0 and selector 0; rdy is given with the correct byte.
  - Follow-up: the same pc afterwards misses again and refills.
- Reset mid-fill:
  - Stimulus: clr asserted after the 8th ack.
  - Required: bus_req=0, rdy=0, set=0 immediately; IDLE after release; the block later refills fully.
- Bus wait states:
  - Stimulus: bus_ack delayed 3 cycles per byte.
  - Required: bus_addr and bus_req are held stable through each wait; byte order and the final selector are unchanged.

Source files
------------

// File: rtl/cache_fill_controller.sv
// Read/fill side of the SuperFX 512-byte instruction cache.
// Serves fetches from cache RAM on a hit. On a miss it fetches the whole
// 16-byte block from the bus, then emits a set/selector strobe so the owner
// of the dirty bits can mark the block valid. Fetches outside the window go
// straight to the bus as single-byte reads.
module cache_fill_controller #(
  parameter int BLOCKS      = 32,
  parameter int BLOCK_BYTES = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic [15:0]       pc,
  input  logic [15:0]       cbr,
  input  logic              flush,
  input  logic [BLOCKS-1:0] dirty_bits,
  output logic              set,
  output logic [BLOCKS-1:0] selector,
  output logic              rdy,
  output logic [7:0]        data,
  output logic              bus_req,
  output logic [15:0]       bus_addr,
  input  logic              bus_ack,
  input  logic [7:0]        bus_data
);

  localparam int BLK_W = $clog2(BLOCKS);
  localparam int OFF_W = BLK_W + 4;
  localparam int WORDS = BLOCKS * BLOCK_BYTES;

  typedef enum logic [2:0] {
    S_IDLE, S_HIT, S_FILL, S_MARK, S_SERVE, S_BYPASS
  } state_t;

  state_t            r_state, w_state;
  logic [3:0]        r_cnt, w_cnt;
  logic              r_abort, w_abort;
  logic [15:4]       r_pc, w_pc;        // block-aligned address of the request
  logic [OFF_W-1:0]  r_off, w_off_q;    // offset of the request inside the window
  logic              r_set, w_set;
  logic [BLOCKS-1:0] r_selector, w_selector;
  logic              r_rdy, w_rdy;
  logic [7:0]        r_data, w_data;
  logic              r_bus_req, w_bus_req;
  logic [15:0]       r_bus_addr, w_bus_addr;
  logic              w_ram_we;

  logic [7:0]        r_ram [WORDS];

  logic [15:0]       w_off;
  logic              w_in_win;
  logic [BLK_W-1:0]  w_blk;

  // Window decode on the live pc; pc below cbr wraps to a large offset.
  assign w_off    = pc - cbr;
  assign w_in_win = (w_off < 16'(WORDS));
  assign w_blk    = w_off[OFF_W-1:4];

  assign set      = r_set;
  assign selector = r_selector;
  assign rdy      = r_rdy;
  assign data     = r_data;
  assign bus_req  = r_bus_req;
  assign bus_addr = r_bus_addr;

  // Next-state and next-output decode for every registered value.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and infers a latch.
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_abort    = r_abort;
    w_pc       = r_pc;
    w_off_q    = r_off;
    w_set      = 1'b0;
    w_selector = '0;
    w_rdy      = 1'b0;
    w_data     = r_data;
    w_bus_req  = r_bus_req;
    w_bus_addr = r_bus_addr;
    w_ram_we   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_pc    = pc[15:4];
          w_off_q = w_off[OFF_W-1:0];
          if (!w_in_win) begin
            w_state    = S_BYPASS;
            w_bus_req  = 1'b1;
            w_bus_addr = pc;
          end else if (dirty_bits[w_blk]) begin
            w_state = S_HIT;
          end else begin
            // cbr is 16-byte aligned, so cbr + {blk,4'h0} is pc with byte zeroed.
            w_state    = S_FILL;
            w_cnt      = 4'd0;
            w_abort    = 1'b0;
            w_bus_req  = 1'b1;
            w_bus_addr = {pc[15:4], 4'h0};
          end
        end
      end
      S_HIT: begin
        w_rdy   = 1'b1;
        w_data  = r_ram[r_off];
        w_state = S_IDLE;
      end
      S_FILL: begin
        if (flush) w_abort = 1'b1;
        if (bus_ack) begin
          w_ram_we   = 1'b1;
          w_cnt      = r_cnt + 4'd1;
          w_bus_addr = {r_pc, r_cnt + 4'd1};
          if (r_cnt == 4'd15) begin
            w_bus_req = 1'b0;
            w_state   = S_MARK;
          end
        end
      end
      S_MARK: begin
        // A flush in this very cycle must also suppress the strobe.
        w_abort = r_abort | flush;
        if (!(r_abort || flush)) begin
          w_set      = 1'b1;
          w_selector = {{(BLOCKS-1){1'b0}}, 1'b1} << r_off[OFF_W-1:4];
        end
        w_state = S_SERVE;
      end
      S_SERVE: begin
        w_rdy   = 1'b1;
        w_data  = r_ram[r_off];
        w_state = S_IDLE;
      end
      S_BYPASS: begin
        if (bus_ack) begin
          w_data    = bus_data;
          w_rdy     = 1'b1;
          w_bus_req = 1'b0;
          w_state   = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_abort    <= 1'b0;
      r_pc       <= '0;
      r_off      <= '0;
      r_set      <= 1'b0;
      r_selector <= '0;
      r_rdy      <= 1'b0;
      r_data     <= 8'h00;
      r_bus_req  <= 1'b0;
      r_bus_addr <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_abort    <= w_abort;
      r_pc       <= w_pc;
      r_off      <= w_off_q;
      r_set      <= w_set;
      r_selector <= w_selector;
      r_rdy      <= w_rdy;
      r_data     <= w_data;
      r_bus_req  <= w_bus_req;
      r_bus_addr <= w_bus_addr;
    end
  end

  // Cache RAM write port, filled in byte order during a miss.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; validity lives entirely in the dirty bits.
    if (w_ram_we) r_ram[{r_off[OFF_W-1:4], r_cnt}] <= bus_data;
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Self-checking bench for cache_fill_controller: directed test-plan cases
// followed by randomized fetches, all checked against a transaction-level
// model of the cache (valid bits plus the byte image of every filled block).
module tb_cache_fill_controller;

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic [15:0] pc;
  logic [15:0] cbr;
  logic        flush;
  logic [31:0] dirty_bits = '0;
  logic        set;
  logic [31:0] selector;
  logic        rdy;
  logic [7:0]  data;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_ack;
  logic [7:0]  bus_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus responder configuration and log of completed reads.
  int          bus_wait = 0;
  bit          bus_mix  = 1'b0;
  int          bus_cyc  = 0;
  logic [15:0] hold_addr;
  logic [15:0] reads[$];

  // Reference model: which blocks are valid and what each cached byte holds.
  logic [31:0] model_valid = '0;
  logic [7:0]  model_ram [512];

  always #5 clk = ~clk;

  cache_fill_controller dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .pc         (pc),
    .cbr        (cbr),
    .flush      (flush),
    .dirty_bits (dirty_bits),
    .set        (set),
    .selector   (selector),
    .rdy        (rdy),
    .data       (data),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_data   (bus_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bus_byte(input logic [15:0] a);
    return bus_mix ? (a[7:0] ^ {a[11:8], a[15:12]}) : a[7:0];
  endfunction

  // Owner of the valid bits: a flush clears them, a set strobe marks one block.
  always @(posedge clk) begin
    if (flush)    dirty_bits <= '0;
    else if (set) dirty_bits <= dirty_bits | selector;
  end

  // Bus slave: acks after bus_wait idle cycles; address must hold while waiting.
  always @(negedge clk) begin
    bus_ack = 1'b0;
    if (clr || !bus_req) begin
      bus_cyc = 0;
    end else begin
      if (bus_cyc == 0) hold_addr = bus_addr;
      else check("bus_addr_hold", 32'(bus_addr), 32'(hold_addr));
      if (bus_cyc >= bus_wait) begin
        bus_ack  = 1'b1;
        bus_data = bus_byte(bus_addr);
        reads.push_back(bus_addr);
        bus_cyc  = 0;
      end else begin
        bus_cyc++;
      end
    end
  end

  // One fetch. flush_at / reset_at: number of completed bus reads after which
  // a flush pulse or a reset is applied (-1 = never).
  task automatic fetch(input logic [15:0] a, input int flush_at, input int reset_at);
    logic [15:0] off;
    logic [15:0] base;
    logic [15:0] exp_reads[$];
    logic [31:0] exp_sel;
    logic [7:0]  exp_data;
    logic [7:0]  got_data;
    logic [31:0] sel_seen;
    bit          in_win, hit, got_rdy, flushed;
    int          blk, nset, viol, cyc, bad, exp_nset;

    off      = a - cbr;
    in_win   = (off < 16'd512);
    blk      = int'(off[8:4]);
    hit      = in_win && model_valid[blk];
    base     = cbr + 16'(blk * 16);
    got_rdy  = 1'b0;
    flushed  = 1'b0;
    nset     = 0;
    viol     = 0;
    cyc      = 0;
    sel_seen = '0;
    got_data = '0;
    reads.delete();

    @(negedge clk);
    req = 1'b1;
    pc  = a;
    while (!got_rdy && cyc < 400) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (set) begin
        nset++;
        sel_seen = selector;
      end
      if (set && rdy) viol++;
      if (!set && selector != '0) viol++;
      if (rdy) begin
        got_rdy  = 1'b1;
        got_data = data;
        req      = 1'b0;
      end else if (flush_at >= 0 && !flushed && reads.size() >= flush_at) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end else if (reset_at >= 0 && reads.size() >= reset_at) begin
        clr = 1'b1;
        req = 1'b0;
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_set", 32'(set), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        // The partially filled block stays invalid.
        check("rst_dirty", dirty_bits, model_valid);
        reads.delete();
        return;
      end
    end
    flush = 1'b0;
    req   = 1'b0;
    if (!got_rdy) begin
      check("rdy_timeout", 32'(got_rdy), 32'd1);
      return;
    end

    if (flushed) model_valid = '0;
    exp_nset = 0;
    exp_sel  = '0;
    if (!in_win) begin
      exp_reads.push_back(a);
      exp_data = bus_byte(a);
    end else if (hit) begin
      exp_data = model_ram[off[8:0]];
      // Accept edge, one cycle in HIT, rdy registered on the next edge.
      check("hit_latency", 32'(cyc), 32'd2);
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp_reads.push_back(base + 16'(i));
        model_ram[blk * 16 + i] = bus_byte(base + 16'(i));
      end
      exp_data = model_ram[off[8:0]];
      if (!flushed) begin
        exp_nset         = 1;
        exp_sel          = 32'd1 << blk;
        model_valid[blk] = 1'b1;
      end
    end

    bad = 0;
    for (int i = 0; i < reads.size() && i < exp_reads.size(); i++)
      if (reads[i] !== exp_reads[i]) bad++;
    check("n_reads", 32'(reads.size()), 32'(exp_reads.size()));
    check("read_order", 32'(bad), 32'd0);
    check("n_set", 32'(nset), 32'(exp_nset));
    check("selector", sel_seen, exp_sel);
    check("data", 32'(got_data), 32'(exp_data));
    check("rdy_set_excl", 32'(viol), 32'd0);
    check("dirty", dirty_bits, model_valid);
  endtask

  initial begin
    logic [15:0] a;
    int fa;

    clr   = 1'b1;
    req   = 1'b0;
    pc    = '0;
    cbr   = 16'h8000;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_set", 32'(set), 32'd0);
    check("reset_selector", selector, 32'd0);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_bus_req", 32'(bus_req), 32'd0);
    check("reset_bus_addr", 32'(bus_addr), 32'd0);
    clr = 1'b0;

    // Cold miss, then a hit on the freshly filled block.
    fetch(16'h8123, -1, -1);
    check("block18_valid", 32'(dirty_bits[18]), 32'd1);
    fetch(16'h812A, -1, -1);

    // Window boundary: last block, one past the end, and below cbr.
    fetch(16'h81FF, -1, -1);
    fetch(16'h8200, -1, -1);
    fetch(16'h7FFF, -1, -1);

    // Flush mid-fill: completes and serves, but no set; then refills.
    fetch(16'h8045, 5, -1);
    fetch(16'h8045, -1, -1);

    // Reset mid-fill, then the block refills in full.
    fetch(16'h8067, -1, 8);
    fetch(16'h8067, -1, -1);

    // Bus wait states.
    bus_wait = 3;
    fetch(16'h8099, -1, -1);
    fetch(16'h809C, -1, -1);
    bus_wait = 0;

    // Randomized fetches, with a different bus data pattern.
    bus_mix = 1'b1;
    model_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int t = 0; t < 48; t++) begin
      if (t % 12 == 0) cbr = {16'($urandom_range(0, 4095)), 4'h0} & 16'hFFF0;
      if ($urandom_range(0, 3) != 0)
        a = cbr + 16'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
      else
        a = 16'($urandom);
      fa       = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : -1;
      bus_wait = $urandom_range(0, 3);
      fetch(a, fa, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
